// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if: start/done handshake bundle for the sequential binary-to-BCD converter.
//   start : request a conversion (driven by master)
//   bin   : unsigned binary operand, IN_W bits (driven by master)
//   busy  : conversion in progress (driven by slave)
//   done  : one-cycle completion pulse (driven by slave)
//   bcd   : result digits, 4*NDIG bits, ones digit in [3:0] (driven by slave)
interface bin2bcd_seq_if #(
    parameter int IN_W = 8,
    parameter int NDIG = 3
);
    logic                start;
    logic [IN_W-1:0]     bin;
    logic                busy;
    logic                done;
    logic [4*NDIG-1:0]   bcd;

    modport master (
        output start,
        output bin,
        input  busy,
        input  done,
        input  bcd
    );

    modport slave (
        input  start,
        input  bin,
        output busy,
        output done,
        output bcd
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, one input bit per clock.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, overrides everything
//   bus : slave side of bin2bcd_seq_if (start, bin in; busy, done, bcd out)
// A start seen in IDLE captures bin; IN_W shift-add-3 steps follow, after which bcd is
// updated together with a one-cycle done pulse. bcd holds between completions.
module bin2bcd_seq #(
    parameter int IN_W = 8,
    parameter int NDIG = 3
) (
    input  logic          clk,
    input  logic          rst,
    bin2bcd_seq_if.slave  bus
);
    localparam int CNT_W = $clog2(IN_W + 1);
    localparam int BCD_W = 4 * NDIG;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_W - 1);

    typedef enum logic {
        StIdle  = 1'b0,
        StShift = 1'b1
    } state_e;

    state_e             r_state;
    state_e             w_state_next;
    logic [IN_W-1:0]    r_shift;
    logic [BCD_W-1:0]   r_scratch;
    logic [BCD_W-1:0]   r_bcd;
    logic [CNT_W-1:0]   r_count;
    logic               r_done;
    logic [BCD_W-1:0]   w_adj;
    logic [BCD_W-1:0]   w_scratch_shifted;
    logic               w_accept;
    logic               w_last;

    // Add-3 on every digit >= 5, including the top one; each digit wraps mod 16.
    always_comb begin
        w_adj = r_scratch;
        for (int i = 0; i < NDIG; i++) begin
            if (r_scratch[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
            end
        end
        // Bits shifted out of the scratch top are dropped.
        w_scratch_shifted = {w_adj[BCD_W-2:0], r_shift[IN_W-1]};
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = StShift;
                end
            end
            StShift: begin
                if (r_count == LAST_CNT) begin
                    w_last       = 1'b1;
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_shift   <= '0;
            r_scratch <= '0;
            r_count   <= '0;
            r_bcd     <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_last;
            if (w_accept) begin
                r_shift   <= bus.bin;
                r_scratch <= '0;
                r_count   <= '0;
            end else if (r_state == StShift) begin
                r_scratch <= w_scratch_shifted;
                r_shift   <= {r_shift[IN_W-2:0], 1'b0};
                r_count   <= r_count + CNT_W'(1);
            end
            if (w_last) begin
                r_bcd <= w_scratch_shifted;
            end
        end
    end

    assign bus.busy = (r_state == StShift);
    assign bus.done = r_done;
    assign bus.bcd  = r_bcd;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: randomized self-checking bench for bin2bcd_seq against a decimal
// arithmetic reference (digits from / and %).
module tb_bin2bcd_seq;
    logic clk;
    logic rst;

    bin2bcd_seq_if #(.IN_W(8), .NDIG(3)) bus ();

    bin2bcd_seq #(.IN_W(8), .NDIG(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_errors;
    logic [11:0] exp_bcd;   // last completed result, tracked by the bench

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] ref_bcd(input int v);
        logic [11:0] r;
        r[3:0]  = 4'((v % 10));
        r[7:4]  = 4'(((v / 10) % 10));
        r[11:8] = 4'(((v / 100) % 10));
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One conversion; noisy: bin wiggles every cycle and start pulses at cycle 3 while busy.
    task automatic convert(input int v, input bit noisy);
        int  cyc;
        int  busy_cyc;
        bit  seen;
        logic [11:0] bcd_now;
        bus.start = 1'b1;
        bus.bin   = 8'(v);
        tick();                     // E0
        bus.start = 1'b0;
        cyc       = 0;
        busy_cyc  = bus.busy ? 1 : 0;
        seen      = 1'b0;
        while (!seen && cyc < 20) begin
            if (noisy) begin
                bus.bin   = 8'($urandom);
                bus.start = (cyc == 2);
            end
            tick();
            bus.start = 1'b0;
            cyc++;
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                if (bus.busy) busy_cyc++;
                check_eq("bcd_hold", 32'(bus.bcd), 32'(exp_bcd));
            end
        end
        check_eq("done_seen", 32'(seen), 32'd1);
        check_eq("done_lat", cyc, 8);
        check_eq("busy_cycles", busy_cyc, 8);
        check_eq("busy_at_done", 32'(bus.busy), 32'd0);
        exp_bcd = ref_bcd(v);
        bcd_now = bus.bcd;
        check_eq($sformatf("bcd_%0d", v), 32'(bcd_now), 32'(exp_bcd));
        check_eq("digits_le9", 32'((bcd_now[3:0] <= 9) && (bcd_now[7:4] <= 9)
                                    && (bcd_now[11:8] <= 9)), 32'd1);
        tick();
        check_eq("done_one_cycle", 32'(bus.done), 32'd0);
        check_eq("bcd_after", 32'(bus.bcd), 32'(exp_bcd));
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        exp_bcd   = '0;
        bus.start = 1'b0;
        bus.bin   = '0;
        rst       = 1'b1;
        tick();
        tick();
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_bcd", 32'(bus.bcd), 32'd0);
        rst = 1'b0;
        tick();

        // Directed values.
        convert(0, 1'b0);
        convert(255, 1'b0);
        convert(225, 1'b0);
        convert(99, 1'b0);
        convert(100, 1'b0);
        convert(42, 1'b1);

        // Start held high: completions at cycles 8 and 17 after first acceptance.
        begin
            int done_a;
            int done_b;
            done_a    = -1;
            done_b    = -1;
            bus.start = 1'b1;
            bus.bin   = 8'd10;
            tick();                 // E0
            bus.bin = 8'd137;
            for (int c = 1; c <= 20; c++) begin
                tick();
                if (bus.done) begin
                    if (done_a < 0) begin
                        done_a = c;
                        exp_bcd = ref_bcd(10);
                    end else if (done_b < 0) begin
                        done_b = c;
                        exp_bcd = ref_bcd(137);
                    end
                end
                if (c >= 8 && c < 17) check_eq("b2b_bcd_mid", 32'(bus.bcd), 32'(ref_bcd(10)));
                if (c == 17) begin
                    bus.start = 1'b0;
                    check_eq("b2b_bcd_2", 32'(bus.bcd), 32'(ref_bcd(137)));
                end
            end
            check_eq("b2b_done_a", done_a, 8);
            check_eq("b2b_done_b", done_b, 17);
            bus.start = 1'b0;
        end

        // Reset in the middle of a conversion.
        begin
            int stray;
            stray     = 0;
            bus.start = 1'b1;
            bus.bin   = 8'd77;
            tick();                 // E0
            bus.start = 1'b0;
            tick();
            tick();
            tick();
            rst = 1'b1;
            tick();
            check_eq("midrst_busy", 32'(bus.busy), 32'd0);
            check_eq("midrst_done", 32'(bus.done), 32'd0);
            check_eq("midrst_bcd", 32'(bus.bcd), 32'd0);
            rst     = 1'b0;
            exp_bcd = '0;
            for (int c = 0; c < 12; c++) begin
                tick();
                if (bus.done) stray++;
            end
            check_eq("midrst_no_done", stray, 0);
            convert(77, 1'b0);
        end

        // Exhaustive sweep with random noise on idle inputs.
        for (int v = 0; v < 256; v++) begin
            convert(v, 1'($urandom_range(0, 1)));
        end
        // A few more random operands.
        for (int k = 0; k < 20; k++) begin
            convert(int'($urandom_range(0, 255)), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
